// File: rtl/razor_transition_monitor_if.sv
// Error-event channel from the transition monitor to the recovery controller.
// A single pending event is accepted when evt_valid & evt_ready.
interface razor_transition_monitor_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  evt_valid;
   logic [DATA_WIDTH-1:0] evt_mask;
   logic                  evt_ready;

   modport master (output evt_valid, output evt_mask, input evt_ready);
   modport slave  (input evt_valid, input evt_mask, output evt_ready);
endinterface

// File: rtl/razor_transition_monitor.sv
// Multi-bit transition monitor: flags polarity-selected bit transitions, treats those
// inside the detection window as timing errors, and reports them as sticky flags, a
// saturating count, an alarm, and a single-entry event to the recovery controller.
module razor_transition_monitor #(
   parameter int DATA_WIDTH    = 8,
   parameter int CNT_WIDTH     = 8,
   parameter int ERR_THRESHOLD = 4,
   parameter int EDGE_MODE     = 0
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_window,
   input  logic                  i_clear,
   output logic [DATA_WIDTH-1:0] o_transition,
   output logic [DATA_WIDTH-1:0] o_err_flags,
   output logic [CNT_WIDTH-1:0]  o_err_count,
   output logic                  o_alarm,
   output logic                  o_overflow,
   razor_transition_monitor_if.master evt_if
);
   typedef enum logic {UNPRIMED = 1'b0, ARMED = 1'b1} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_prev;
   logic [DATA_WIDTH-1:0] r_transition;
   logic [DATA_WIDTH-1:0] r_err_flags;
   logic [CNT_WIDTH-1:0]  r_err_count;
   logic                  r_alarm;
   logic                  r_overflow;
   logic                  r_evt_valid;
   logic [DATA_WIDTH-1:0] r_evt_mask;

   logic [DATA_WIDTH-1:0] w_edge;
   logic [DATA_WIDTH-1:0] w_hit;
   logic                  w_any_hit;
   logic                  w_accept;
   logic [CNT_WIDTH-1:0]  w_cnt_next;

   // Edge vector for the configured polarity; unsupported modes fall back to "any".
   always_comb begin
      w_edge = i_data ^ r_prev;
      case (EDGE_MODE)
         32'sd1:  w_edge = i_data & ~r_prev;
         32'sd2:  w_edge = ~i_data & r_prev;
         default: w_edge = i_data ^ r_prev;
      endcase
   end

   assign w_hit     = (r_state == ARMED) ? (w_edge & {DATA_WIDTH{i_window}}) : {DATA_WIDTH{1'b0}};
   assign w_any_hit = |w_hit;
   assign w_accept  = r_evt_valid & evt_if.evt_ready;

   // Next error count: clear reloads with this cycle's hit, otherwise saturating increment.
   always_comb begin
      w_cnt_next = r_err_count;
      if (i_clear) begin
         w_cnt_next = CNT_WIDTH'(w_any_hit);
      end else if (w_any_hit && (r_err_count != {CNT_WIDTH{1'b1}})) begin
         w_cnt_next = r_err_count + CNT_WIDTH'(1);
      end else begin
         w_cnt_next = r_err_count;
      end
   end

   // Priming FSM plus all registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= UNPRIMED;
         r_prev       <= {DATA_WIDTH{1'b0}};
         r_transition <= {DATA_WIDTH{1'b0}};
         r_err_flags  <= {DATA_WIDTH{1'b0}};
         r_err_count  <= {CNT_WIDTH{1'b0}};
         r_alarm      <= 1'b0;
         r_overflow   <= 1'b0;
         r_evt_valid  <= 1'b0;
         r_evt_mask   <= {DATA_WIDTH{1'b0}};
      end else begin
         r_prev <= i_data;
         case (r_state)
            UNPRIMED: begin
               r_state      <= ARMED;
               r_transition <= {DATA_WIDTH{1'b0}};
            end
            ARMED: begin
               r_state      <= ARMED;
               r_transition <= w_edge;
            end
            default: begin
               r_state      <= UNPRIMED;
               r_transition <= {DATA_WIDTH{1'b0}};
            end
         endcase

         r_err_flags <= (i_clear ? {DATA_WIDTH{1'b0}} : r_err_flags) | w_hit;
         r_err_count <= w_cnt_next;
         r_alarm     <= (32'(w_cnt_next) >= ERR_THRESHOLD);

         // A hit merged into an unaccepted event sets overflow; clear takes priority.
         if (!r_evt_valid || w_accept) begin
            r_evt_valid <= w_any_hit;
            r_evt_mask  <= w_hit;
            r_overflow  <= i_clear ? 1'b0 : r_overflow;
         end else if (w_any_hit) begin
            r_evt_valid <= 1'b1;
            r_evt_mask  <= r_evt_mask | w_hit;
            r_overflow  <= i_clear ? 1'b0 : 1'b1;
         end else begin
            r_evt_valid <= r_evt_valid;
            r_evt_mask  <= r_evt_mask;
            r_overflow  <= i_clear ? 1'b0 : r_overflow;
         end
      end
   end

   assign o_transition     = r_transition;
   assign o_err_flags      = r_err_flags;
   assign o_err_count      = r_err_count;
   assign o_alarm          = r_alarm;
   assign o_overflow       = r_overflow;
   assign evt_if.evt_valid = r_evt_valid;
   assign evt_if.evt_mask  = r_evt_mask;
endmodule
